frame_buffer_writer: RTL and testbench

- Write-side companion to the frame buffer scan-out path: accepts a 32-bit pixel stream (e.g. from the rasterizer) and writes it into SDRAM over the Avalon-MM 64-bit master port.
- Packs two pixels per 64-bit word and buffers words in a small FIFO so memory stalls do not stall the producer.
- Also fills the whole frame region with a single colour on request (clear).

---
 rtl/frame_buffer_writer_pkg.sv | 46 ++++
 rtl/frame_buffer_write_fifo.sv | 61 ++++++
 rtl/frame_buffer_writer.sv | 210 +++++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_writer_pkg.sv
// Shared constants and payload types for the frame buffer write path.
package frame_buffer_writer_pkg;

    localparam int unsigned PIX_W  = 32;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned ADDR_W = 29;
    localparam int unsigned BE_W   = 8;

    localparam logic [1:0] FBW_STATE_STREAM = 2'd0;
    localparam logic [1:0] FBW_STATE_DRAIN  = 2'd1;
    localparam logic [1:0] FBW_STATE_CLEAR  = 2'd2;

    localparam logic [BE_W-1:0] BYTEENABLE_FULL = 8'hFF;
    localparam logic [BE_W-1:0] BYTEENABLE_LOW  = 8'h0F;

    localparam logic [PIX_W-1:0] MAGENTA = 32'h00ff00ff;

    // Packed word plus a marker telling the master to restart at the frame base.
    typedef struct packed {
        logic              restart;
        logic              half;
        logic [WORD_W-1:0] data;
    } fbw_word_t;

    function automatic fbw_word_t fbw_make_word(
        input logic             restart,
        input logic             half,
        input logic [PIX_W-1:0] hi,
        input logic [PIX_W-1:0] lo
    );
        fbw_word_t w;
        w.restart = restart;
        w.half    = half;
        w.data    = {hi, lo};
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] fbw_next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] first,
        input logic [ADDR_W-1:0] last
    );
        return (a == last) ? first : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/frame_buffer_write_fifo.sv
// Show-ahead synchronous FIFO holding packed words between pixel packer and memory master.
module frame_buffer_write_fifo #(
    parameter int unsigned WIDTH      = 65,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_clock,
    input  logic                  i_aclr,
    input  logic                  i_sclr,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_wrreq,
    input  logic                  i_rdreq,
    output logic [WIDTH-1:0]      o_q,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_usedw
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_usedw = r_count;
    assign o_q     = r_mem[r_rd_ptr];

    assign w_wr = i_wrreq && !o_full;
    assign w_rd = i_rdreq && !o_empty;

    always_ff @(posedge i_clock or posedge i_aclr) begin
        if (i_aclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are ever observed.
    always_ff @(posedge i_clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// Packs a 32-bit pixel stream into 64-bit SDRAM writes and can fill the frame with one colour.
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int unsigned ADDRESS         = 0,
    parameter int unsigned LENGTH          = 0,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_start,
    input  logic               clear_req,
    input  logic [PIX_W-1:0]   clear_color,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_W-1:0]  address,
    output logic [7:0]         burstcount,
    input  logic               waitrequest,
    output logic [WORD_W-1:0]  writedata,
    output logic [BE_W-1:0]    byteenable,
    output logic               write,
    output logic               read,
    input  logic [WORD_W-1:0]  readdata,
    input  logic               readdatavalid
);

    localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 2;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(ADDRESS / 8);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ADDRESS / 8 + LENGTH / 8 - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_ready_en;
    logic                  r_half_pending;
    logic [PIX_W-1:0]      r_half_data;
    logic                  r_restart_next;
    logic                  r_push_valid;
    fbw_word_t             r_push_word;
    logic [PIX_W-1:0]      r_clear_color;
    logic                  r_clear_last;
    logic                  r_write;
    logic [ADDR_W-1:0]     r_address;
    logic [WORD_W-1:0]     r_writedata;
    logic [BE_W-1:0]       r_byteenable;
    logic [ADDR_W-1:0]     r_addr_cnt;
    logic                  r_frame_done;
    logic                  r_busy;

    fbw_word_t             w_fifo_q;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] w_fifo_usedw;
    logic                  w_fifo_aclr;
    logic [LVL_W-1:0]      w_level;
    logic                  w_accept;
    logic                  w_flush;
    logic                  w_drained;
    logic                  w_complete;
    logic                  w_slot_free;
    logic                  w_load_fifo;
    logic                  w_load_clear;
    logic [ADDR_W-1:0]     w_issue_addr;
    logic                  w_unused_inputs;

    assign w_unused_inputs = &{1'b0, readdata, readdatavalid};

    // Words in flight: FIFO, push stage and the word on the bus all count against capacity.
    assign w_level   = LVL_W'(w_fifo_usedw) + LVL_W'(r_push_valid) + LVL_W'(r_write);
    assign pix_ready = r_ready_en && (r_state == FBW_STATE_STREAM) &&
                       (w_level < LVL_W'(FIFO_DEPTH)) && !clear_req;
    assign w_accept  = pix_valid && pix_ready;

    assign w_flush   = (r_state == FBW_STATE_DRAIN) && r_half_pending &&
                       !r_push_valid && !w_fifo_full;
    assign w_drained = (r_state == FBW_STATE_DRAIN) && w_fifo_empty && !r_write &&
                       !r_push_valid && !r_half_pending;

    assign w_complete   = r_write && !waitrequest;
    assign w_slot_free  = !r_write || w_complete;
    assign w_load_fifo  = w_slot_free && !w_fifo_empty && (r_state != FBW_STATE_CLEAR);
    assign w_load_clear = w_slot_free && (r_state == FBW_STATE_CLEAR) && !r_clear_last;
    assign w_issue_addr = w_fifo_q.restart ? FIRST : r_addr_cnt;
    assign w_fifo_aclr  = !reset_n;

    frame_buffer_write_fifo #(
        .WIDTH      ($bits(fbw_word_t)),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clock (clock),
        .i_aclr  (w_fifo_aclr),
        .i_sclr  (1'b0),
        .i_data  (r_push_word),
        .i_wrreq (r_push_valid),
        .i_rdreq (w_load_fifo),
        .o_q     (w_fifo_q),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_usedw (w_fifo_usedw)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= FBW_STATE_STREAM;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FBW_STATE_STREAM: if (clear_req) w_state_next = FBW_STATE_DRAIN;
            FBW_STATE_DRAIN:  if (w_drained) w_state_next = FBW_STATE_CLEAR;
            FBW_STATE_CLEAR:  if (w_complete && r_clear_last) w_state_next = FBW_STATE_STREAM;
            default:          w_state_next = FBW_STATE_STREAM;
        endcase
    end

    // Pixel packer: pairs pixels, flushes a lone half on frame start or drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en     <= 1'b0;
            r_half_pending <= 1'b0;
            r_half_data    <= '0;
            r_restart_next <= 1'b0;
            r_push_valid   <= 1'b0;
            r_push_word    <= '0;
            r_clear_color  <= '0;
        end else begin
            r_ready_en   <= 1'b1;
            r_push_valid <= 1'b0;
            if ((r_state == FBW_STATE_STREAM) && clear_req) r_clear_color <= clear_color;
            if (w_accept) begin
                if (pix_start) begin
                    if (r_half_pending) begin
                        r_push_valid <= 1'b1;
                        r_push_word  <= fbw_make_word(r_restart_next, 1'b1, '0, r_half_data);
                    end
                    r_restart_next <= 1'b1;
                    r_half_data    <= pix_data;
                    r_half_pending <= 1'b1;
                end else if (r_half_pending) begin
                    r_push_valid   <= 1'b1;
                    r_push_word    <= fbw_make_word(r_restart_next, 1'b0, pix_data, r_half_data);
                    r_restart_next <= 1'b0;
                    r_half_pending <= 1'b0;
                end else begin
                    r_half_data    <= pix_data;
                    r_half_pending <= 1'b1;
                end
            end else if (w_flush) begin
                r_push_valid   <= 1'b1;
                r_push_word    <= fbw_make_word(r_restart_next, 1'b1, '0, r_half_data);
                r_restart_next <= 1'b0;
                r_half_pending <= 1'b0;
            end else if (w_drained) begin
                r_restart_next <= 1'b0;
            end
        end
    end

    // Avalon master: one word on the bus, refilled on the completing edge for back-to-back writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= BYTEENABLE_FULL;
            r_addr_cnt   <= FIRST;
            r_clear_last <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= w_complete && (r_address == LAST);
            r_busy       <= (r_state != FBW_STATE_STREAM) || r_write ||
                            !w_fifo_empty || r_push_valid;
            if (w_drained) begin
                r_addr_cnt   <= FIRST;
                r_clear_last <= 1'b0;
            end else if (w_load_fifo) begin
                r_write      <= 1'b1;
                r_address    <= w_issue_addr;
                r_writedata  <= w_fifo_q.data;
                r_byteenable <= w_fifo_q.half ? BYTEENABLE_LOW : BYTEENABLE_FULL;
                r_addr_cnt   <= fbw_next_addr(w_issue_addr, FIRST, LAST);
            end else if (w_load_clear) begin
                r_write      <= 1'b1;
                r_address    <= r_addr_cnt;
                r_writedata  <= {r_clear_color, r_clear_color};
                r_byteenable <= BYTEENABLE_FULL;
                r_addr_cnt   <= fbw_next_addr(r_addr_cnt, FIRST, LAST);
                if (r_addr_cnt == LAST) r_clear_last <= 1'b1;
            end else if (w_complete) begin
                r_write <= 1'b0;
            end
        end
    end

    assign write      = r_write;
    assign address    = r_address;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign burstcount = 8'h01;
    assign read       = 1'b0;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed self-checking bench for frame_buffer_writer (base 0x100, 32-byte frame).
module tb_frame_buffer_writer;
    import frame_buffer_writer_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        pix_start;
    logic        clear_req;
    logic [31:0] clear_color;
    logic        busy;
    logic        frame_done;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        write;
    logic        read;
    logic [63:0] readdata;
    logic        readdatavalid;

    frame_buffer_writer #(
        .ADDRESS         (32'h100),
        .LENGTH          (32),
        .FIFO_DEPTH      (16),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_start     (pix_start),
        .clear_req     (clear_req),
        .clear_color   (clear_color),
        .busy          (busy),
        .frame_done    (frame_done),
        .address       (address),
        .burstcount    (burstcount),
        .waitrequest   (waitrequest),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .write         (write),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [28:0] mon_addr[$];
    logic [63:0] mon_data[$];
    logic [7:0]  mon_be[$];
    logic [28:0] last_addr;
    logic [28:0] done_addr;
    int          done_cnt;
    int          stab_err;
    int          hold_cycles;
    int          leak;
    bit          clr_win;
    bit          hold_prev;
    logic [28:0] h_addr;
    logic [63:0] h_data;
    logic [7:0]  h_be;
    bit          after_done;
    logic        busy_at_done;
    logic        busy_after;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (after_done) begin
                busy_after = busy;
                after_done = 1'b0;
            end
            if (frame_done) begin
                done_cnt++;
                done_addr    = last_addr;
                busy_at_done = busy;
                after_done   = 1'b1;
            end
            if (clr_win) begin
                if (frame_done) clr_win = 1'b0;
                else if (pix_ready) leak++;
            end
            if (hold_prev) begin
                if (write !== 1'b1 || address !== h_addr || writedata !== h_data || byteenable !== h_be)
                    stab_err++;
            end
            hold_prev = write && waitrequest;
            if (hold_prev) hold_cycles++;
            h_addr = address;
            h_data = writedata;
            h_be   = byteenable;
            if (write && !waitrequest) begin
                mon_addr.push_back(address);
                mon_data.push_back(writedata);
                mon_be.push_back(byteenable);
                last_addr = address;
            end
        end
    end

    task automatic do_reset();
        reset_n     = 1'b0;
        pix_valid   = 1'b0;
        pix_start   = 1'b0;
        pix_data    = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        waitrequest = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_addr.delete();
        mon_data.delete();
        mon_be.delete();
        done_cnt = 0; stab_err = 0; hold_cycles = 0; leak = 0;
        clr_win = 1'b0; hold_prev = 1'b0; after_done = 1'b0;
        busy_at_done = 1'bx; busy_after = 1'bx; done_addr = '0; last_addr = '0;
    endtask

    task automatic send_pix(input logic [31:0] d, input logic st, input int budget, output bit ok);
        ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_start = st;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (pix_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
        pix_valid = 1'b0;
        pix_start = 1'b0;
    endtask

    task automatic stream(input int first_val, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            send_pix(32'(first_val + i), i == 0, 20, ok);
            chk("pix_accept", 64'(ok), 64'd1);
        end
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int c = 0;
        while (mon_addr.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        repeat (4) @(negedge clock);
        chk(tag, 64'(mon_addr.size()), 64'(n));
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [28:0] ea,
                             input logic [63:0] ed, input logic [63:0] mask, input logic [7:0] ebe);
        chk({tag, "_present"}, 64'(mon_addr.size() > idx), 64'd1);
        if (mon_addr.size() > idx) begin
            chk({tag, "_addr"}, 64'(mon_addr[idx]), 64'(ea));
            chk({tag, "_data"}, mon_data[idx] & mask, ed & mask);
            chk({tag, "_be"},   64'(mon_be[idx]), 64'(ebe));
        end
    endtask

    initial begin
        int  acc;
        bit  ok;
        logic [63:0] all1;
        logic [63:0] low32;
        all1  = '1;
        low32 = 64'h00000000_ffffffff;
        readdata      = '0;
        readdatavalid = 1'b0;

        // Reset values, sampled while reset is held
        reset_n = 1'b0; pix_valid = 1'b0; pix_start = 1'b0; pix_data = '0;
        clear_req = 1'b0; clear_color = '0; waitrequest = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_write",      64'(write),      64'd0);
        chk("rst_address",    64'(address),    64'd0);
        chk("rst_writedata",  writedata,       64'd0);
        chk("rst_byteenable", 64'(byteenable), 64'hFF);
        chk("rst_pix_ready",  64'(pix_ready),  64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_read",       64'(read),       64'd0);
        chk("rst_burstcount", 64'(burstcount), 64'd1);

        // Basic pairing: 1,2,3,4
        do_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("idle_pix_ready", 64'(pix_ready), 64'd1);
        stream(1, 4);
        wait_writes("t1_cnt", 2, 50);
        chk_write("t1_w0", 0, 29'h20, 64'h00000002_00000001, all1, BYTEENABLE_FULL);
        chk_write("t1_w1", 1, 29'h21, 64'h00000004_00000003, all1, BYTEENABLE_FULL);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // Stall on the first write
        do_reset();
        waitrequest = 1'b1;
        stream(1, 4);
        repeat (5) @(posedge clock);
        #1;
        waitrequest = 1'b0;
        wait_writes("t2_cnt", 2, 50);
        chk("t2_held",   64'(hold_cycles >= 5), 64'd1);
        chk("t2_stable", 64'(stab_err), 64'd0);
        chk_write("t2_w0", 0, 29'h20, 64'h00000002_00000001, all1, BYTEENABLE_FULL);
        chk_write("t2_w1", 1, 29'h21, 64'h00000004_00000003, all1, BYTEENABLE_FULL);

        // Address wrap and frame_done
        do_reset();
        stream(1, 10);
        wait_writes("t3_cnt", 5, 80);
        chk_write("t3_w3", 3, 29'h23, 64'h00000008_00000007, all1, BYTEENABLE_FULL);
        chk_write("t3_w4", 4, 29'h20, 64'h0000000a_00000009, all1, BYTEENABLE_FULL);
        chk("t3_done_cnt",  64'(done_cnt),  64'd1);
        chk("t3_done_addr", 64'(done_addr), 64'h23);

        // pix_start with a pending half pixel
        do_reset();
        stream(5, 3);
        send_pix(32'd8, 1'b1, 20, ok);
        chk("t4_start_accept", 64'(ok), 64'd1);
        send_pix(32'd9, 1'b0, 20, ok);
        chk("t4_pix9_accept", 64'(ok), 64'd1);
        wait_writes("t4_cnt", 3, 50);
        chk_write("t4_w0", 0, 29'h20, 64'h00000006_00000005, all1, BYTEENABLE_FULL);
        chk_write("t4_w1", 1, 29'h21, 64'h00000000_00000007, low32, BYTEENABLE_LOW);
        chk_write("t4_w2", 2, 29'h20, 64'h00000009_00000008, all1, BYTEENABLE_FULL);

        // Clear with three words queued behind a stalled bus
        do_reset();
        waitrequest = 1'b1;
        stream(1, 6);
        repeat (4) @(posedge clock);
        #1;
        clear_req   = 1'b1;
        clear_color = MAGENTA;
        clr_win     = 1'b1;
        @(posedge clock);
        #1;
        clear_req   = 1'b0;
        clear_color = '0;
        waitrequest = 1'b0;
        wait_writes("t5_cnt", 7, 100);
        chk_write("t5_w0", 0, 29'h20, 64'h00000002_00000001, all1, BYTEENABLE_FULL);
        chk_write("t5_w1", 1, 29'h21, 64'h00000004_00000003, all1, BYTEENABLE_FULL);
        chk_write("t5_w2", 2, 29'h22, 64'h00000006_00000005, all1, BYTEENABLE_FULL);
        for (int k = 0; k < 4; k++)
            chk_write("t5_clr", 3 + k, 29'(32'h20 + k), {MAGENTA, MAGENTA}, all1, BYTEENABLE_FULL);
        chk("t5_ready_leak", 64'(leak),         64'd0);
        chk("t5_done_cnt",   64'(done_cnt),     64'd1);
        chk("t5_busy_at",    64'(busy_at_done), 64'd1);
        chk("t5_busy_after", 64'(busy_after),   64'd0);
        chk("t5_ready_back", 64'(pix_ready),    64'd1);

        // Backpressure fill, then asynchronous reset
        do_reset();
        waitrequest = 1'b1;
        acc = 0;
        ok  = 1'b1;
        for (int i = 0; i < 40 && ok; i++) begin
            send_pix(32'(i + 1), i == 0, 10, ok);
            if (ok) acc++;
        end
        chk("t6_accepted", 64'(acc),       64'd32);
        chk("t6_ready_lo", 64'(pix_ready), 64'd0);
        chk("t6_write_hi", 64'(write),     64'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_write", 64'(write),     64'd0);
        chk("t6_rst_ready", 64'(pix_ready), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        waitrequest = 1'b0;
        repeat (3) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
